// File: rtl/inverter_pipe_bank_if.sv
// Stream, mask and status signals of the programmable inverter pipeline.
// Carries out_par only when INV_PARITY_EN is defined.
interface inverter_pipe_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in1;
    logic             in_valid;
    logic             in_ready;
    logic             mask_wr;
    logic [WIDTH-1:0] mask_in;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] out2;
    logic             out_valid;
    logic             out_ready;
`ifdef INV_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in1,
        output in_valid,
        output mask_wr,
        output mask_in,
        output out_ready,
        input  in_ready,
        input  mask_q,
        input  out2,
`ifdef INV_PARITY_EN
        input  out_par,
`endif
        input  out_valid
    );

    modport slave (
        input  in1,
        input  in_valid,
        input  mask_wr,
        input  mask_in,
        input  out_ready,
        output in_ready,
        output mask_q,
        output out2,
`ifdef INV_PARITY_EN
        output out_par,
`endif
        output out_valid
    );
endinterface

// File: rtl/inverter_pipe_bank.sv
// WIDTH-channel programmable inverter (in1 ^ mask) behind a DEPTH-stage elastic pipeline.
// Optional per-beat even parity when INV_PARITY_EN is defined.
module inverter_pipe_bank #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] INIT_MASK = {WIDTH{1'b1}}
) (
    input logic                 clk1,
    input logic                 rst1_n,
    inverter_pipe_bank_if.slave bus
);
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;
    logic [WIDTH-1:0]            r_mask;
    logic [DEPTH-1:0]            w_adv;
    logic                        w_accept;
    logic [WIDTH-1:0]            w_beat;

    // Advance chain runs from the output back to stage 0, so ready is combinational.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = r_valid[DEPTH-1] & bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
        end
    end

    assign bus.in_ready  = ~r_valid[0] | w_adv[0];
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_beat        = bus.in1 ^ r_mask;
    assign bus.mask_q    = r_mask;
    assign bus.out2      = r_data[DEPTH-1];
    assign bus.out_valid = r_valid[DEPTH-1];

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            r_mask <= INIT_MASK;
        end else if (bus.mask_wr) begin
            r_mask <= bus.mask_in;
        end
    end

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            if (w_accept) begin
                r_valid[0] <= 1'b1;
                r_data[0]  <= w_beat;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= r_data[i-1];
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef INV_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            r_par <= '0;
        end else begin
            if (w_accept) begin
                r_par[0] <= ^w_beat;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_par[i] <= r_par[i-1];
                end
            end
        end
    end

    assign bus.out_par = r_par[DEPTH-1];
`endif
endmodule
